// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, issues in-order instruction fetches and buffers returned words for the IF/ID slot.
// Define FETCH_BUF2_EN for a two-entry buffer (full throughput with 1-cycle memory); the default build has one entry.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [11:0] id_imm
);
`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [2:0]  DEPTH3 = 3'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]         r_pc;
    logic [1:0]          r_out;
    logic [1:0]          r_cnt;
    logic [1:0]          r_disc;
    logic [DEPTH*32-1:0] r_inf;
    logic [DEPTH*32-1:0] r_bi;
    logic [DEPTH*32-1:0] r_bp;
    logic [DEPTH*32-1:0] w_inf_nxt;
    logic [DEPTH*32-1:0] w_bi_nxt;
    logic [DEPTH*32-1:0] w_bp_nxt;
    logic                w_pop;
    logic                w_fire;
    logic                w_rsp;
    logic                w_take;
    logic [1:0]          w_inf_idx;
    logic [1:0]          w_buf_idx;

    // Credit counts both in-flight fetches (stale ones included) and buffered words.
    assign w_pop          = (r_cnt != 2'd0) && !stall;
    assign imem_req_valid = reset && !redirect_valid &&
                            (({1'b0, r_out} + {1'b0, r_cnt} - {2'b00, w_pop}) < DEPTH3);
    assign imem_req_addr  = r_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_rsp          = imem_rsp_valid && (r_out != 2'd0);
    assign w_take         = w_rsp && (r_disc == 2'd0);
    assign w_inf_idx      = r_out - r_disc - {1'b0, w_take};
    assign w_buf_idx      = r_cnt - {1'b0, w_pop};

    // Both queues shift toward entry 0 on pop; the new entry lands just past the survivors.
    always_comb begin
        w_inf_nxt = w_take ? (r_inf >> 32) : r_inf;
        w_bi_nxt  = w_pop ? (r_bi >> 32) : r_bi;
        w_bp_nxt  = w_pop ? (r_bp >> 32) : r_bp;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_fire && k == int'(w_inf_idx)) w_inf_nxt[k*32 +: 32] = r_pc;
            if (w_take && k == int'(w_buf_idx)) begin
                w_bi_nxt[k*32 +: 32] = imem_rsp_data;
                w_bp_nxt[k*32 +: 32] = r_inf[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_out  <= '0;
            r_cnt  <= '0;
            r_disc <= '0;
            r_inf  <= '0;
            r_bi   <= {DEPTH{NOP}};
            r_bp   <= '0;
        end else if (redirect_valid) begin
            r_pc   <= redirect_pc;
            r_cnt  <= '0;
            r_out  <= r_out - {1'b0, w_rsp};
            r_disc <= r_out - {1'b0, w_rsp};
        end else begin
            if (w_fire) r_pc <= r_pc + 32'd4;
            if (w_rsp && !w_take) r_disc <= r_disc - 2'd1;
            r_out <= r_out + {1'b0, w_fire} - {1'b0, w_rsp};
            r_cnt <= r_cnt + {1'b0, w_take} - {1'b0, w_pop};
            r_inf <= w_inf_nxt;
            r_bi  <= w_bi_nxt;
            r_bp  <= w_bp_nxt;
        end
    end

    assign id_valid  = r_cnt != 2'd0;
    assign id_instr  = id_valid ? r_bi[31:0] : NOP;
    assign id_pc     = id_valid ? r_bp[31:0] : 32'h0;
    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];
    assign id_rd     = id_instr[11:7];
    assign id_rs1    = id_instr[19:15];
    assign id_imm    = id_instr[31:20];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against a queue-based model of the fetch stage, plus directed scenarios.
module tb_fetch_stage;
`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [11:0] id_imm;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd), .id_rs1(id_rs1), .id_imm(id_imm)
    );

    typedef struct { logic [31:0] pc; bit stale; } inf_t;
    typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
    inf_t        m_inf[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] memq[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a + 32'h00A0_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance model and memory.
    task automatic step(input bit rdy, input bit rsp_en, input bit redir, input logic [31:0] rpc, input bit stl);
        bit          pop;
        bit          exp_rv;
        logic [31:0] exp_ins;
        inf_t        e;
        @(negedge clk);
        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        stall          = stl;
        imem_rsp_valid = rsp_en && memq.size() > 0;
        imem_rsp_data  = imem_rsp_valid ? word_of(memq[0]) : 32'h0;
        #1;
        pop     = m_buf.size() > 0 && !stl;
        exp_rv  = !redir && ((m_inf.size() + m_buf.size() - (pop ? 1 : 0)) < DEPTH);
        exp_ins = m_buf.size() > 0 ? m_buf[0].ins : 32'h0000_0013;
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, m_pc);
        chk("id_valid", id_valid, m_buf.size() > 0);
        chk("id_instr", id_instr, exp_ins);
        if (m_buf.size() > 0) chk("id_pc", id_pc, m_buf[0].pc);
        chk("id_opcode", id_opcode, exp_ins[6:0]);
        chk("id_funct3", id_funct3, exp_ins[14:12]);
        chk("id_funct7", id_funct7, exp_ins[31:25]);
        chk("id_rd", id_rd, exp_ins[11:7]);
        chk("id_rs1", id_rs1, exp_ins[19:15]);
        chk("id_imm", id_imm, exp_ins[31:20]);
        if (redir) begin
            if (imem_rsp_valid && m_inf.size() > 0) void'(m_inf.pop_front());
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_buf.delete();
            m_pc = rpc;
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (imem_rsp_valid && m_inf.size() > 0) begin
                e = m_inf.pop_front();
                if (!e.stale) m_buf.push_back('{ins: imem_rsp_data, pc: e.pc});
            end
            if (exp_rv && rdy) begin
                m_inf.push_back('{pc: m_pc, stale: 1'b0});
                m_pc += 32'd4;
            end
        end
        if (imem_rsp_valid) void'(memq.pop_front());
        if (imem_req_valid && rdy) memq.push_back(imem_req_addr);
    endtask

    task automatic nstep(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    // Asserts reset mid-cycle with a response pending; at most one pre-reset response is left to arrive late.
    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_id_valid", id_valid, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_opcode", id_opcode, 32'h13);
        chk("rst_rd", id_rd, 32'd0);
        chk("rst_imm", id_imm, 32'd0);
        repeat (2) @(posedge clk);
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        #2 reset = 1'b1;
        m_inf.delete();
        m_buf.delete();
        m_pc = 32'h0;
        while (memq.size() > 1) void'(memq.pop_back());
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        do_reset();
        step(1, 1, 0, 0, 0);
        chk("c0_req_valid", imem_req_valid, 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        step(1, 1, 0, 0, 0);
        chk("c1_req_valid", imem_req_valid, (DEPTH == 2) ? 32'd1 : 32'd0);
        chk("c1_req_addr", imem_req_addr, 32'h4);
        step(1, 1, 0, 0, 0);
        chk("c2_id_valid", id_valid, 32'd1);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_id_instr", id_instr, 32'h00A0_0093);
        chk("c2_id_rd", id_rd, 32'd1);
        chk("c2_id_imm", id_imm, 32'h00A);
        n = 0;
        while (!(m_buf.size() > 0 && m_buf[0].pc == 32'h8) && n < 10) begin
            step(1, 1, 0, 0, 0);
            n++;
        end
        chk("reach_pc8", n < 10, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 1);
            chk("stall_id_pc", id_pc, 32'h8);
            chk("stall_id_valid", id_valid, 32'd1);
        end
        chk("stall_credit_out", imem_req_valid, 32'd0);
        n = 0;
        do begin
            step(1, 1, 0, 0, 0);
            n++;
        end while (!(id_valid && id_pc != 32'h8) && n < 6);
        chk("resume_pc", id_pc, 32'hC);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk("notready_drained", id_valid, 32'd0);
        nstep(4);
        step(1, 1, 1, 32'h100, 0);
        step(1, 1, 0, 0, 0);
        chk("redir_t1_id_valid", id_valid, 32'd0);
        chk("redir_t1_req_valid", imem_req_valid, 32'd1);
        chk("redir_t1_addr", imem_req_addr, 32'h100);
        step(1, 1, 0, 0, 0);
        chk("redir_t2_id_valid", id_valid, 32'd0);
        step(1, 1, 0, 0, 0);
        chk("redir_t3_id_valid", id_valid, 32'd1);
        chk("redir_t3_id_pc", id_pc, 32'h100);
        chk("redir_t3_id_instr", id_instr, 32'h00A0_0193);
        nstep(3);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h200, 0);
        step(1, 1, 0, 0, 0);
        chk("stale_t1_addr", imem_req_addr, 32'h200);
        chk("stale_t1_id_valid", id_valid, 32'd0);
        step(1, 1, 0, 0, 0);
        chk("stale_t2_id_valid", id_valid, 32'd0);
        step(1, 1, 0, 0, 0);
        chk("stale_t3_id_valid", id_valid, 32'd1);
        chk("stale_t3_id_pc", id_pc, 32'h200);
        nstep(3);
        step(1, 1, 1, 32'h300, 1);
        step(1, 1, 0, 0, 0);
        chk("redir_stall_id_valid", id_valid, 32'd0);
        chk("redir_stall_id_instr", id_instr, 32'h0000_0013);
        nstep(3);
        step(1, 1, 1, 32'hFFFF_FFFC, 0);
        step(1, 1, 0, 0, 0);
        chk("wrap_req_valid", imem_req_valid, 32'd1);
        chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0);
        chk("wrap_addr_zero", imem_req_addr, 32'h0);
        nstep(2);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        do_reset();
        step(1, 1, 0, 0, 0);
        chk("rr_c0_req_valid", imem_req_valid, 32'd1);
        chk("rr_c0_addr", imem_req_addr, 32'h0);
        chk("rr_c0_id_valid", id_valid, 32'd0);
        step(1, 1, 0, 0, 0);
        chk("rr_c1_id_valid", id_valid, 32'd0);
        step(1, 1, 0, 0, 0);
        chk("rr_c2_id_pc", id_pc, 32'h0);
        chk("rr_c2_id_instr", id_instr, 32'h00A0_0093);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined core, directly upstream of the decode controller. Holds the PC, issues requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PCs. Presents the IF/ID slot (instruction, PC, pre-split decode fields) to the decoder. Honours hazard-unit stalls and branch/jump redirects, discarding stale in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  fetch address (current PC).
- imem_rsp_valid  in  1  instruction word returned, in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch/jump from EX; flush.
- redirect_pc  in  32  redirect target.
- stall  in  1  hazard unit holds IF/ID slot.
- id_valid  out  1  IF/ID slot holds a live instruction.
- id_instr  out  32  instruction; 32'h0000_0013 (NOP) when id_valid=0.
- id_pc  out  32  PC of id_instr.
- id_opcode  out  7  id_instr[6:0].
- id_funct3  out  3  id_instr[14:12].
- id_funct7  out  7  id_instr[31:25].
- id_rd  out  5  id_instr[11:7].
- id_rs1  out  5  id_instr[19:15].
- id_imm  out  12  id_instr[31:20].

## Operation
- DEPTH = 2 (see Configuration). Instruction buffer: DEPTH-entry FIFO of {instr, pc}; in-flight PC queue: DEPTH entries; counters outstanding, count, discard.
- Request: imem_req_valid = !redirect_valid & (outstanding + count − pop < DEPTH), pop = id_valid & !stall. On handshake: push PC to in-flight queue, PC ← PC+4 (mod 2^32), outstanding+1.
- Response: imem_rsp_valid with discard>0 → dropped, discard−1, outstanding−1. Otherwise pop in-flight PC, push {data, pc} to buffer, outstanding−1. Response with outstanding=0 is ignored.
- IF/ID slot = buffer head, registered; id_valid = (count≠0). Pop when id_valid & !stall. Push and pop in same cycle allowed.
- Redirect (priority over stall, request, response push): PC ← redirect_pc; buffer and in-flight queue cleared; discard ← outstanding − (1 if a response arrives this cycle); id_valid 0 next cycle. No request issued in the redirect cycle.
- Decode fields are pure slices of id_instr (NOP when id_valid=0).

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, id_valid 0, id_instr 32'h0000_0013, id_pc 0, fields = NOP slices, all counters 0. First request in the first cycle after reset release.
- Latency: request accepted cycle t, response t+1 → id_valid at t+2. With 1-cycle memory and no stall, one instruction per cycle.
- Redirect at t: request of redirect_pc earliest t+1; its instruction in IF/ID earliest t+3.
- Stall: slot outputs stable; requests continue until credit exhausted, then imem_req_valid=0, imem_req_addr held.
- imem_req_addr stable while imem_req_valid=1 and !imem_req_ready.
- Reset mid-operation: all state cleared asynchronously; responses to pre-reset requests ignored (outstanding=0).

## Configuration
- FETCH_BUF2_EN defined: DEPTH=2, up to two outstanding/buffered instructions, full throughput with 1-cycle memory.
- Undefined: DEPTH=1, single entry; with 1-cycle memory, one instruction every 2 cycles; all other rules unchanged.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr-based words -> requests 0x0,0x4,0x8 on consecutive cycles; id_pc 0x0 at cycle 2, then +4 per cycle.
- stall held 3 cycles with id_pc=0x8 -> id_instr/id_pc stable 3 cycles, imem_req_valid drops once credit exhausted, resumes 0xC.. without loss or duplication.
- redirect_valid with redirect_pc=0x100 while 2 fetches outstanding -> both stale responses dropped, next id_pc=0x100 exactly 3 cycles after redirect.
- imem_req_ready=0 for 4 cycles -> imem_req_addr held, id_valid falls after buffer drains, no PC skip.
- redirect and stall asserted same cycle -> redirect wins, slot flushed to NOP, id_valid 0 next cycle.
- reset asserted with requests outstanding -> outputs at reset values immediately; late imem_rsp_valid ignored; fetch restarts at RESET_PC.
